// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg: shared arbiter state/owner types and AXI response codes.
package ysyx_24110015_pkg;
    typedef enum logic [1:0] {IDLE, IFU_R, LSU_R, LSU_W} arb_state_t;
    typedef enum logic {OWNER_IFU, OWNER_LSU} arb_owner_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/ysyx_24110015_axi_lite_if.sv
// axi_lite_if: 32-bit AXI-lite bundle with master and slave views.
interface axi_lite_if;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    modport master(
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
    modport slave(
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ysyx_24110015_arb_pick.sv
// ysyx_24110015_arb_pick: chooses the next grant from pending requests and the last owner.
module ysyx_24110015_arb_pick
    import ysyx_24110015_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       ifu_req_i,
    input  logic       lsu_rd_i,
    input  logic       lsu_wr_i,
    input  arb_owner_t last_grant_i,
    output arb_state_t grant_o
);
    logic ifu_wins;
    // On a conflict the IFU only wins when fairness is on and the LSU owned the bus last.
    assign ifu_wins = ifu_req_i & (~(lsu_rd_i | lsu_wr_i) | (RR_EN & (last_grant_i == OWNER_LSU)));
    assign grant_o  = ifu_wins ? IFU_R : lsu_rd_i ? LSU_R : lsu_wr_i ? LSU_W : IDLE;
endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// ysyx_24110015_axi_arbiter: IFU/LSU to single AXI-lite slave arbiter, grant held per transaction.
// Define ARB_RR_EN to alternate the winner on IFU/LSU conflicts instead of fixed LSU priority.
module ysyx_24110015_axi_arbiter
    import ysyx_24110015_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    axi_lite_if.slave  ifu_if,
    axi_lite_if.slave  lsu_if,
    axi_lite_if.master mem_if
);
    arb_state_t state_q, state_d, pick_s;
    arb_owner_t last_grant;
    logic       ifu_g, lsu_r, lsu_w, idle, r_done, b_done;

    assign ifu_g  = state_q == IFU_R;
    assign lsu_r  = state_q == LSU_R;
    assign lsu_w  = state_q == LSU_W;
    assign idle   = state_q == IDLE;
    assign r_done = mem_if.rvalid & mem_if.rready;
    assign b_done = mem_if.bvalid & mem_if.bready;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
    arb_owner_t last_grant_q, last_grant_d;
    assign last_grant_d = (ifu_g & r_done) ? OWNER_IFU :
                          ((lsu_r & r_done) | (lsu_w & b_done)) ? OWNER_LSU : last_grant_q;
    always_ff @(posedge clk) begin
        if (!rst) last_grant_q <= OWNER_LSU;
        else      last_grant_q <= last_grant_d;
    end
    assign last_grant = last_grant_q;
`else
    localparam bit RR = 1'b0;
    assign last_grant = OWNER_LSU;
`endif

    ysyx_24110015_arb_pick #(.RR_EN(RR)) u_pick (
        .ifu_req_i   (ifu_if.arvalid),
        .lsu_rd_i    (lsu_if.arvalid),
        .lsu_wr_i    (lsu_if.awvalid | lsu_if.wvalid),
        .last_grant_i(last_grant),
        .grant_o     (pick_s)
    );

    always_comb begin
        state_d = state_q;
        state_d = idle ? pick_s : ((lsu_w ? b_done : r_done) ? IDLE : state_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    assign mem_if.arvalid = (ifu_g & ifu_if.arvalid) | (lsu_r & lsu_if.arvalid);
    assign mem_if.araddr  = ifu_g ? ifu_if.araddr : lsu_if.araddr;
    assign mem_if.awvalid = lsu_w & lsu_if.awvalid;
    assign mem_if.awaddr  = lsu_if.awaddr;
    assign mem_if.wvalid  = lsu_w & lsu_if.wvalid;
    assign mem_if.wdata   = lsu_if.wdata;
    assign mem_if.wstrb   = lsu_if.wstrb;
    // Idle drains any stale response so the slave can never stall the bus.
    assign mem_if.rready  = idle | (ifu_g & ifu_if.rready) | (lsu_r & lsu_if.rready);
    assign mem_if.bready  = idle | (lsu_w & lsu_if.bready);

    assign ifu_if.arready = ifu_g & mem_if.arready;
    assign ifu_if.rvalid  = ifu_g & mem_if.rvalid;
    assign ifu_if.rdata   = mem_if.rdata;
    assign ifu_if.rresp   = mem_if.rresp;
    assign ifu_if.awready = 1'b0;
    assign ifu_if.wready  = 1'b0;
    assign ifu_if.bvalid  = 1'b0;
    assign ifu_if.bresp   = RESP_OKAY;

    assign lsu_if.arready = lsu_r & mem_if.arready;
    assign lsu_if.rvalid  = lsu_r & mem_if.rvalid;
    assign lsu_if.rdata   = mem_if.rdata;
    assign lsu_if.rresp   = mem_if.rresp;
    assign lsu_if.awready = lsu_w & mem_if.awready;
    assign lsu_if.wready  = lsu_w & mem_if.wready;
    assign lsu_if.bvalid  = lsu_w & mem_if.bvalid;
    assign lsu_if.bresp   = mem_if.bresp;
endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// tb_ysyx_24110015_axi_arbiter: vector table, directed corner sequences and randomized traffic vs a grant model.
module tb_ysyx_24110015_axi_arbiter;
    import ysyx_24110015_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_lite_if ifu();
    axi_lite_if lsu();
    axi_lite_if mem();

    ysyx_24110015_axi_arbiter dut (.clk(clk), .rst(rst), .ifu_if(ifu), .lsu_if(lsu), .mem_if(mem));

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int G_NONE = 0, G_IFU = 1, G_LR = 2, G_LW = 3;
    localparam logic [31:0] A_IFU = 32'h8000_0040, A_LSU = 32'h8000_0080;
    localparam logic [31:0] K = 32'hA5A5_0F0F;

    typedef struct {
        bit i, lr, aw, w;
        int g;
    } vec_t;
    vec_t tbl[10];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        ifu.arvalid = 0; ifu.araddr = 0; ifu.rready = 0; ifu.awvalid = 0; ifu.awaddr = 0;
        ifu.wvalid = 0; ifu.wdata = 0; ifu.wstrb = 0; ifu.bready = 0;
        lsu.arvalid = 0; lsu.araddr = 0; lsu.rready = 0; lsu.awvalid = 0; lsu.awaddr = 0;
        lsu.wvalid = 0; lsu.wdata = 0; lsu.wstrb = 0; lsu.bready = 0;
        mem.arready = 0; mem.rvalid = 0; mem.rdata = 0; mem.rresp = 0;
        mem.awready = 0; mem.wready = 0; mem.bvalid = 0; mem.bresp = 0;
    endtask

    // Winner among pending requests: LSU read > LSU write > IFU, unless fairness hands a conflict to IFU.
    function automatic int pick(input bit i, input bit lr, input bit lw, input int last);
        int lk;
        lk = lr ? G_LR : G_LW;
        if (!i && !(lr || lw)) return G_NONE;
        if (!(lr || lw)) return G_IFU;
        if (!i) return lk;
        return (RR && last == 1) ? G_IFU : lk;
    endfunction

    function automatic int seen_grant();
        if (mem.arvalid) return mem.araddr == A_IFU ? G_IFU : mem.araddr == A_LSU ? G_LR : 9;
        if (mem.awvalid || mem.wvalid) return G_LW;
        return G_NONE;
    endfunction

    task automatic finish_read(input bit is_ifu, input logic [31:0] data, input string nm);
        mem.arready = 1;
        tick;
        if (is_ifu) ifu.arvalid = 0; else lsu.arvalid = 0;
        mem.arready = 0;
        mem.rvalid = 1; mem.rdata = data; mem.rresp = RESP_OKAY;
        ifu.rready = is_ifu; lsu.rready = !is_ifu;
        #1;
        chk(nm, {ifu.rvalid, lsu.rvalid, is_ifu ? ifu.rdata : lsu.rdata}, {is_ifu, !is_ifu, data});
        tick;
        mem.rvalid = 0; ifu.rready = 0; lsu.rready = 0;
    endtask

    int owner, last, n_done, s_st, s_dly;
    bit ifu_pend, lsu_pend, lsu_wr, s_aw, s_w, s_wr;
    bit oi, olr, olw, on, d_ifu_ar, d_lsu_ar, d_aw, d_w, d_r, d_b;
    logic [31:0] ifu_addr, lsu_addr, lsu_data, s_addr;
    logic [3:0]  lsu_strb;
    logic [1:0]  s_resp;
    logic [63:0] exp_v, act_v;

    initial begin
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, G_NONE},
            '{1'b1, 1'b0, 1'b0, 1'b0, G_IFU},
            '{1'b0, 1'b1, 1'b0, 1'b0, G_LR},
            '{1'b0, 1'b0, 1'b1, 1'b0, G_LW},
            '{1'b0, 1'b0, 1'b0, 1'b1, G_LW},
            '{1'b0, 1'b0, 1'b1, 1'b1, G_LW},
            '{1'b0, 1'b1, 1'b1, 1'b0, G_LR},
            '{1'b1, 1'b1, 1'b0, 1'b0, RR ? G_IFU : G_LR},
            '{1'b1, 1'b0, 1'b1, 1'b0, RR ? G_IFU : G_LW},
            '{1'b1, 1'b1, 1'b1, 1'b1, RR ? G_IFU : G_LR}
        };
        clr;
        tick;
        for (int k = 0; k < 10; k++) begin
            rst = 0;
            ifu.arvalid = tbl[k].i; ifu.araddr = A_IFU;
            lsu.arvalid = tbl[k].lr; lsu.araddr = A_LSU;
            lsu.awvalid = tbl[k].aw; lsu.wvalid = tbl[k].w;
            tick;
            chk("tbl_reset", {mem.arvalid, mem.awvalid, mem.wvalid, mem.rready, mem.bready}, 5'b00011);
            rst = 1;
            tick;
            chk($sformatf("tbl_grant_%0d", k), 64'(seen_grant()), 64'(tbl[k].g));
        end

        // Reset held with an IFU request pending, then released.
        clr; rst = 0;
        ifu.arvalid = 1; ifu.araddr = 32'h8000_0000; mem.arready = 1;
        repeat (3) tick;
        chk("rst_hold", {mem.arvalid, ifu.arready, mem.rready, mem.bready}, 4'b0011);
        mem.arready = 0; rst = 1;
        tick;
        chk("rst_release", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_0000});

        // IFU read, data two cycles after the address handshake.
        mem.arready = 1;
        #1 chk("ifu_arready", {ifu.arready, lsu.arready}, 2'b10);
        tick;
        ifu.arvalid = 0; mem.arready = 0;
        tick;
        tick;
        mem.rvalid = 1; mem.rdata = 32'h0000_0413; mem.rresp = RESP_OKAY; ifu.rready = 1;
        #1 chk("ifu_rdata", {ifu.rvalid, lsu.rvalid, ifu.rdata}, {2'b10, 32'h0000_0413});
        tick;
        mem.rvalid = 0; ifu.rready = 0;
        #1 chk("ifu_back_idle", {mem.rready, mem.bready, ifu.rvalid}, 3'b110);

        // Simultaneous requests: LSU first, one idle cycle, then IFU.
        ifu.arvalid = 1; ifu.araddr = 32'h8000_0004;
        lsu.arvalid = 1; lsu.araddr = 32'h8000_1000;
        tick;
        chk("conflict_first", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_1000});
        finish_read(0, 32'h1111_2222, "conflict_lsu_r");
        chk("conflict_gap", {mem.arvalid, ifu.arready, mem.rready}, 3'b001);
        tick;
        chk("conflict_second", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_0004});
        finish_read(1, 32'h3333_4444, "conflict_ifu_r");
`ifdef ARB_RR_EN
        lsu.arvalid = 1; lsu.araddr = 32'h8000_1004;
        tick;
        finish_read(0, 32'h5555_6666, "rr_lsu_alone");
        ifu.arvalid = 1; ifu.araddr = 32'h8000_0004;
        lsu.arvalid = 1; lsu.araddr = 32'h8000_1000;
        tick;
        chk("rr_ifu_first", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_0004});
        finish_read(1, 32'h7777_8888, "rr_ifu_r");
        tick;
        chk("rr_lsu_second", {mem.arvalid, mem.araddr}, {1'b1, 32'h8000_1000});
        finish_read(0, 32'h9999_AAAA, "rr_lsu_r");
`endif

        // LSU write with a delayed wready while an IFU read waits.
        lsu.awvalid = 1; lsu.awaddr = 32'h8000_2000;
        lsu.wvalid = 1; lsu.wdata = 32'hDEAD_BEEF; lsu.wstrb = 4'b0011;
        tick;
        chk("wr_aw_route", {mem.awvalid, mem.awaddr, mem.arvalid}, {1'b1, 32'h8000_2000, 1'b0});
        chk("wr_w_route", {mem.wvalid, mem.wstrb, mem.wdata}, {1'b1, 4'b0011, 32'hDEAD_BEEF});
        ifu.arvalid = 1; ifu.araddr = 32'h8000_0008;
        mem.arready = 1; mem.awready = 1;
        #1 chk("wr_awready", {lsu.awready, ifu.arready, mem.arvalid}, 3'b100);
        tick;
        lsu.awvalid = 0; mem.awready = 0;
        #1 chk("wr_w_wait", {lsu.wready, mem.wvalid, mem.awvalid, ifu.arready}, 4'b0100);
        tick;
        mem.wready = 1;
        #1 chk("wr_wready", {lsu.wready, ifu.arready}, 2'b10);
        tick;
        lsu.wvalid = 0; mem.wready = 0;
        mem.bvalid = 1; mem.bresp = RESP_SLVERR; lsu.bready = 1;
        #1 chk("wr_bresp_err", {lsu.bvalid, lsu.bresp, ifu.bvalid, ifu.rvalid}, {1'b1, 2'b10, 2'b00});
        tick;
        mem.bvalid = 0; lsu.bready = 0;
        #1 chk("wr_b_once", {lsu.bvalid, mem.bready, mem.rready, ifu.arready}, 4'b0110);
        tick;
        chk("ifu_after_wr", {ifu.arready, mem.arvalid, mem.araddr}, {2'b11, 32'h8000_0008});
        finish_read(1, 32'hCAFE_F00D, "ifu_after_wr_r");

        // Reset between address acceptance and the data beat.
        lsu.arvalid = 1; lsu.araddr = 32'h8000_3000;
        tick;
        mem.arready = 1;
        tick;
        lsu.arvalid = 0; mem.arready = 0;
        #1 chk("rst_mid_busy", {mem.rready, mem.bready}, 2'b00);
        rst = 0;
        tick;
        rst = 1;
        mem.rvalid = 1; mem.rdata = 32'h0BAD_0BAD; lsu.rready = 1; ifu.rready = 1;
        #1 chk("rst_mid_drain", {ifu.rvalid, lsu.rvalid, mem.rready}, 3'b001);
        tick;
        mem.rvalid = 0; lsu.rready = 0; ifu.rready = 0;
        #1 chk("rst_mid_idle", {mem.arvalid, mem.awvalid, mem.wvalid, mem.rready, mem.bready}, 5'b00011);

        // Randomized traffic against a transaction-level grant model.
        clr; rst = 0;
        tick;
        rst = 1;
        owner = G_NONE; last = 1; n_done = 0; s_st = 0; s_dly = 0;
        ifu_pend = 0; lsu_pend = 0; lsu_wr = 0; s_aw = 0; s_w = 0; s_wr = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_data = 0; lsu_strb = 0; s_addr = 0; s_resp = 0;
        d_ifu_ar = 0; d_lsu_ar = 0; d_aw = 0; d_w = 0; d_r = 0; d_b = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (d_ifu_ar) ifu.arvalid = 0;
            if (d_lsu_ar) lsu.arvalid = 0;
            if (d_aw) lsu.awvalid = 0;
            if (d_w) lsu.wvalid = 0;
            if (d_r) mem.rvalid = 0;
            if (d_b) mem.bvalid = 0;
            ifu.rready = 1'($urandom_range(0, 1));
            lsu.rready = 1'($urandom_range(0, 1));
            lsu.bready = 1'($urandom_range(0, 1));
            mem.arready = 1'($urandom_range(0, 1));
            mem.awready = 1'($urandom_range(0, 1));
            mem.wready = 1'($urandom_range(0, 1));
            if (!ifu_pend && $urandom_range(0, 3) == 0) begin
                ifu_pend = 1; ifu_addr = $urandom & ~32'h3;
                ifu.arvalid = 1; ifu.araddr = ifu_addr;
            end
            if (!lsu_pend && $urandom_range(0, 3) == 0) begin
                lsu_pend = 1; lsu_wr = 1'($urandom_range(0, 1)); lsu_addr = $urandom & ~32'h3;
                if (lsu_wr) begin
                    lsu_data = $urandom; lsu_strb = 4'($urandom);
                    lsu.awvalid = 1; lsu.awaddr = lsu_addr;
                    lsu.wvalid = 1; lsu.wdata = lsu_data; lsu.wstrb = lsu_strb;
                end else begin
                    lsu.arvalid = 1; lsu.araddr = lsu_addr;
                end
            end
            if (s_st == 1) begin
                if (s_dly == 0) begin
                    s_st = 2;
                    if (s_wr) begin
                        mem.bvalid = 1; mem.bresp = s_resp;
                    end else begin
                        mem.rvalid = 1; mem.rdata = s_addr ^ K; mem.rresp = s_resp;
                    end
                end else s_dly--;
            end
            #1;
            oi = owner == G_IFU; olr = owner == G_LR; olw = owner == G_LW; on = owner == G_NONE;
            exp_v = 64'({(oi & ifu.arvalid) | (olr & lsu.arvalid), oi ? ifu.araddr : lsu.araddr,
                         olw & lsu.awvalid, olw & lsu.wvalid,
                         on | (oi & ifu.rready) | (olr & lsu.rready), on | (olw & lsu.bready),
                         oi & mem.arready, oi & mem.rvalid, olr & mem.arready, olr & mem.rvalid,
                         olw & mem.awready, olw & mem.wready, olw & mem.bvalid, 3'b000});
            act_v = 64'({mem.arvalid, mem.araddr, mem.awvalid, mem.wvalid, mem.rready, mem.bready,
                         ifu.arready, ifu.rvalid, lsu.arready, lsu.rvalid,
                         lsu.awready, lsu.wready, lsu.bvalid, ifu.awready, ifu.wready, ifu.bvalid});
            chk("rand_route", act_v, exp_v);
            d_ifu_ar = ifu.arvalid & ifu.arready;
            d_lsu_ar = lsu.arvalid & lsu.arready;
            d_aw = lsu.awvalid & lsu.awready;
            d_w = lsu.wvalid & lsu.wready;
            d_r = mem.rvalid & mem.rready;
            d_b = mem.bvalid & mem.bready;
            if (mem.arvalid & mem.arready) begin
                s_addr = mem.araddr; s_wr = 0; s_st = 1; s_dly = $urandom_range(0, 3);
                s_resp = $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY;
            end
            if (mem.awvalid & mem.awready) begin
                chk("rand_awaddr", 64'(mem.awaddr), 64'(lsu_addr)); s_aw = 1;
            end
            if (mem.wvalid & mem.wready) begin
                chk("rand_wdata", 64'({mem.wstrb, mem.wdata}), 64'({lsu_strb, lsu_data})); s_w = 1;
            end
            if (s_aw && s_w) begin
                s_aw = 0; s_w = 0; s_wr = 1; s_st = 1; s_dly = $urandom_range(0, 3);
                s_resp = $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY;
            end
            if (ifu.rvalid & ifu.rready) begin
                chk("rand_ifu_r", 64'({ifu.rresp, ifu.rdata}), 64'({s_resp, ifu_addr ^ K}));
                ifu_pend = 0; n_done++;
            end
            if (lsu.rvalid & lsu.rready) begin
                chk("rand_lsu_r", 64'({lsu.rresp, lsu.rdata}), 64'({s_resp, lsu_addr ^ K}));
                lsu_pend = 0; n_done++;
            end
            if (lsu.bvalid & lsu.bready) begin
                chk("rand_lsu_b", 64'(lsu.bresp), 64'(s_resp));
                lsu_pend = 0; n_done++;
            end
            if (d_r || d_b) s_st = 0;
            if (owner == G_NONE)
                owner = pick(ifu.arvalid, lsu.arvalid, lsu.awvalid | lsu.wvalid, last);
            else if ((owner != G_LW && d_r) || (owner == G_LW && d_b)) begin
                last = owner == G_IFU ? 0 : 1;
                owner = G_NONE;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("rand_progress", 64'(n_done > 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24110015_axi_arbiter.md
# ysyx_24110015_axi_arbiter

Two-master, one-slave AXI-lite arbiter placed directly downstream of the LSU and IFU AXI-lite masters, in front of the shared memory/SRAM slave. It grants the slave to one master per transaction and routes that master's request channels to the slave and the slave's response channels back to it. While a transaction is in flight, the grant is held until the slave returns its R or B handshake.

## Interface
- No parameters. Address and data widths are 32 bits, fixed by `axi_lite_if`.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: synchronous, active-low reset.
- `ifu_if  axi_lite_if.slave  –`: IFU port, read-only. Its AW/W/B outputs are driven as `awready=0`, `wready=0`, `bvalid=0`, `bresp=0`.
- `lsu_if  axi_lite_if.slave  –`: LSU port, read and write.
- `mem_if  axi_lite_if.master  –`: port to the downstream slave.

## Operation
- States (enum `arb_state_t`): IDLE, IFU_R, LSU_R, LSU_W.
- IDLE transitions, evaluated each cycle on the current valids:
  - No request pending: stay in IDLE.
  - `lsu.arvalid` → LSU_R.
  - `lsu.awvalid | lsu.wvalid` (without `lsu.arvalid`) → LSU_W.
  - `ifu.arvalid` → IFU_R.
- Default priority: LSU read > LSU write > IFU read.
- IFU_R and LSU_R:
  - Route the granted master's `arvalid`/`araddr` to mem, and mem `arready` back to that master.
  - Route mem `rvalid`/`rdata`/`rresp` to the granted master, and its `rready` to mem.
  - Go to IDLE on the cycle after `mem.rvalid & mem.rready`.
- LSU_W:
  - Route `awvalid`/`awaddr`, `wvalid`/`wdata`/`wstrb`, and `bready` from the LSU.
  - Route `awready`, `wready`, `bvalid`, `bresp` back to the LSU.
  - AW and W may complete in different cycles.
  - Go to IDLE on the cycle after `mem.bvalid & mem.bready`.
- Non-granted master: all of its ready and valid inputs from the arbiter are 0, and its request remains pending.
- Data and address buses to mem carry the granted master's value. In IDLE they carry the LSU's value; mem valids are 0.
- In IDLE, `mem.rready=1` and `mem.bready=1`, so stale responses are drained and discarded. The arbiter does not route them to either master.
- `rresp`/`bresp` pass through unmodified. The arbiter generates no errors.

## Timing
- All outputs are combinational functions of the state register and the routed inputs.
- Reset (`rst=0` at a clock edge): state = IDLE. Consequently:
  - All mem valids = 0.
  - All master-side readys and valids = 0.
  - `mem.rready = mem.bready = 1`.
- Grant latency: a request seen in IDLE at edge N is visible on mem from cycle N+1.
- Back-to-back: after a response handshake there is exactly one IDLE cycle before the next grant.
- Simultaneous IFU and LSU requests in IDLE: LSU wins. The IFU is granted after the LSU transaction completes and one IDLE cycle passes.
- A response handshake and a new request in the same cycle: the new request is not granted until the following IDLE cycle.
- Reset mid-transaction: next state is IDLE and mem valids drop immediately. Any late slave response is absorbed by the IDLE drain.
- The grant never changes while a routed valid is asserted but not yet accepted.

## Configuration
- `ARB_RR_EN` defined:
  - A 1-bit `last_grant` register (reset value LSU) records the owner of the last completed transaction.
  - On an IFU/LSU conflict in IDLE, the master that did not own the last transaction wins.
  - The LSU-internal order (read before write) still applies.
- `ARB_RR_EN` undefined: fixed priority as in Operation, and no `last_grant` register exists.

## Structure
- Shared package `ysyx_24110015_pkg` holds:
  - `arb_state_t`;
  - grant-owner enum `arb_owner_t` {OWNER_IFU, OWNER_LSU};
  - AXI response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
- One sub-module, `ysyx_24110015_arb_pick`: combinational next-owner selection from the request bits and `last_grant`. Its `last_grant` port is tied to OWNER_LSU when `ARB_RR_EN` is undefined.
- The FSM and channel muxing live in the top module.

## Test plan
- Reset:
  - Hold `rst=0` for 3 cycles with `ifu.arvalid=1`.
  - → `mem.arvalid=0`, `ifu.arready=0`, `mem.rready=1`.
  - Release reset → `mem.arvalid=1` and `araddr=ifu.araddr` one cycle later.
- IFU read:
  - `ifu.araddr=0x8000_0000`; slave returns `rdata=0x0000_0413` two cycles after `arready`.
  - → `ifu.rvalid=1` with that data, then state returns to IDLE.
- Conflict:
  - IFU read to 0x8000_0004 and LSU read to 0x8000_1000 both raised in the same cycle.
  - → mem sees 0x8000_1000 first, then 0x8000_0004 after exactly one IDLE cycle.
  - With `ARB_RR_EN`, repeat after a completed LSU transaction → IFU first.
- LSU write:
  - `awaddr=0x8000_2000`, `wdata=0xDEAD_BEEF`, `wstrb=4'b0011`; slave delays `wready` one cycle after `awready`.
  - → mem receives exact values; `lsu.bvalid` is seen once; an IFU read raised meanwhile is held with `ifu.arready=0`.
- Reset mid-read:
  - Assert reset after `arready` but before `rvalid`; slave then returns `rvalid`.
  - → neither master sees `rvalid`; `mem.rready=1` drains it.
- Error pass-through: slave `bresp=2'b10` → `lsu.bresp=2'b10`.
